rsa_precomp: RTL and testbench

Modulus precomputation stage that sits directly upstream of the RSA exponentiation core. Given a 256-bit odd modulus, it computes three values.
- The Montgomery word constant mp = −N⁻¹ mod 2^32. The core's `mp` port consumes it.
- R mod N, with R = 2^256. This is the Montgomery form of 1, used as the accumulator seed.
- R² mod N. This converts `indata` into the Montgomery domain.

The stage runs once per key load; the exponentiation core reuses the results for every message under that key.

---
 rtl/rsa_pkg.sv | 22 ++
 rtl/mont_inv32.sv | 55 +++++
 rtl/rsa_precomp.sv | 130 +++++++++++++
 tb/tb_rsa_precomp.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/rsa_pkg.sv
// Shared constants and types for the RSA precomputation stage and exponentiation core.
package rsa_pkg;

  localparam int unsigned KEY_W   = 256;
  localparam int unsigned WORD_W  = 32;
  localparam int unsigned NWORDS  = KEY_W / WORD_W;
  localparam int unsigned R_STEPS = 2 * KEY_W;
  localparam int unsigned CNT_W   = $clog2(R_STEPS);
  localparam int unsigned IDX_W   = $clog2(WORD_W);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } precomp_state_e;

  // Montgomery arithmetic needs an odd modulus greater than one.
  function automatic logic modulus_ok(input logic [KEY_W-1:0] n);
    return n[0] && (n != KEY_W'(1));
  endfunction

endpackage

// File: rtl/mont_inv32.sv
// Hensel lifting of the word inverse y = N^-1 mod 2^WORD_W, one bit per cycle.
module mont_inv32
  import rsa_pkg::*;
(
  input  logic              clk,
  input  logic              rstn,
  input  logic              go,
  input  logic [WORD_W-1:0] n_lo,
  output logic              done,
  output logic [WORD_W-1:0] inv
);

  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(WORD_W - 1);

  logic [WORD_W-1:0] n_q;
  logic [WORD_W-1:0] p_q;
  logic [WORD_W-1:0] y_q;
  logic [IDX_W-1:0]  idx_q;
  logic              active_q;
  logic              done_q;

  // p tracks N*y mod 2^WORD_W; clearing bit idx of p fixes bit idx of y.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      n_q      <= '0;
      p_q      <= '0;
      y_q      <= '0;
      idx_q    <= '0;
      active_q <= 1'b0;
      done_q   <= 1'b0;
    end else if (go) begin
      n_q      <= n_lo;
      p_q      <= n_lo;
      y_q      <= WORD_W'(1);
      idx_q    <= IDX_W'(1);
      active_q <= 1'b1;
      done_q   <= 1'b0;
    end else if (active_q) begin
      if (p_q[idx_q]) begin
        y_q[idx_q] <= 1'b1;
        p_q        <= p_q + (n_q << idx_q);
      end
      if (idx_q == IDX_LAST) begin
        active_q <= 1'b0;
        done_q   <= 1'b1;
      end else begin
        idx_q <= idx_q + IDX_W'(1);
      end
    end
  end

  assign done = done_q;
  assign inv  = y_q;

endmodule

// File: rtl/rsa_precomp.sv
// Per-key precomputation: mp = -N^-1 mod 2^32, r1 = 2^256 mod N, r2 = 2^512 mod N.
module rsa_precomp
  import rsa_pkg::*;
(
  input  logic              clk,
  input  logic              rstn,
  input  logic              start,
  input  logic [KEY_W-1:0]  modulos,
  output logic              busy,
  output logic              end_flag,
  output logic              err,
  output logic [WORD_W-1:0] mp,
  output logic [KEY_W-1:0]  r1,
  output logic [KEY_W-1:0]  r2
);

  localparam logic [CNT_W-1:0] R1_LAST = CNT_W'(KEY_W - 1);
  localparam logic [CNT_W-1:0] R2_LAST = CNT_W'(R_STEPS - 1);

  precomp_state_e    state_q, state_d;
  logic              accept;
  logic              valid_n;
  logic              finish;

  logic [KEY_W-1:0]  n_q;
  logic [KEY_W-1:0]  r_q;
  logic [KEY_W-1:0]  r1_int_q;
  logic [CNT_W-1:0]  cnt_q;
  logic              err_int_q;

  logic [KEY_W:0]    t;
  logic [KEY_W:0]    n_ext;
  logic [KEY_W-1:0]  r_next;

  logic              inv_done;
  logic [WORD_W-1:0] inv_y;
  logic [WORD_W-1:0] mp_c;

  assign valid_n = modulus_ok(modulos);
  assign mp_c    = ~inv_y + WORD_W'(1);

  mont_inv32 u_inv (
    .clk  (clk),
    .rstn (rstn),
    .go   (accept && valid_n),
    .n_lo (modulos[WORD_W-1:0]),
    .done (inv_done),
    .inv  (inv_y)
  );

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    finish  = 1'b0;
    unique case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          accept  = 1'b1;
          state_d = valid_n ? ST_RUN : ST_DONE;
        end
      end
      ST_RUN: begin
        if ((cnt_q == R2_LAST) && inv_done) begin
          finish  = 1'b1;
          state_d = ST_DONE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // One modular doubling per cycle; the extra top bit absorbs the carry of 2r.
  always_comb begin
    t      = {r_q, 1'b0};
    n_ext  = {1'b0, n_q};
    r_next = (t >= n_ext) ? KEY_W'(t - n_ext) : t[KEY_W-1:0];
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      n_q       <= '0;
      r_q       <= '0;
      r1_int_q  <= '0;
      cnt_q     <= '0;
      err_int_q <= 1'b0;
      mp        <= '0;
      r1        <= '0;
      r2        <= '0;
    end else if (accept) begin
      n_q       <= modulos;
      cnt_q     <= '0;
      err_int_q <= ~valid_n;
      if (valid_n) begin
        r_q <= KEY_W'(1);
      end else begin
        mp <= '0;
        r1 <= '0;
        r2 <= '0;
      end
    end else if (state_q == ST_RUN) begin
      r_q   <= r_next;
      cnt_q <= cnt_q + CNT_W'(1);
      if (cnt_q == R1_LAST) r1_int_q <= r_next;
      if (finish) begin
        mp <= mp_c;
        r1 <= r1_int_q;
        r2 <= r_next;
      end
    end
  end

  // Status flags follow the state one cycle later.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      busy     <= 1'b0;
      end_flag <= 1'b0;
      err      <= 1'b0;
    end else begin
      busy     <= (state_q == ST_RUN);
      end_flag <= (state_q == ST_DONE);
      err      <= (state_q == ST_DONE) && err_int_q;
    end
  end

endmodule

// File: tb/tb_rsa_precomp.sv
// Self-checking bench for rsa_precomp: vector table, result scoreboard, and corner sequences.
module tb_rsa_precomp;
  import rsa_pkg::*;

  localparam int unsigned BW    = 2 * KEY_W + 8;
  localparam int          LAT_V = 513;

  logic              clk;
  logic              rstn;
  logic              start;
  logic [KEY_W-1:0]  modulos;
  logic              busy;
  logic              end_flag;
  logic              err;
  logic [WORD_W-1:0] mp;
  logic [KEY_W-1:0]  r1;
  logic [KEY_W-1:0]  r2;

  rsa_precomp dut (
    .clk      (clk),
    .rstn     (rstn),
    .start    (start),
    .modulos  (modulos),
    .busy     (busy),
    .end_flag (end_flag),
    .err      (err),
    .mp       (mp),
    .r1       (r1),
    .r2       (r2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [KEY_W-1:0]  n;
    logic              err;
    logic [WORD_W-1:0] mp;
    logic [KEY_W-1:0]  r1;
    logic [KEY_W-1:0]  r2;
  } vec_t;

  typedef struct {
    logic              err;
    logic [WORD_W-1:0] mp;
    logic [KEY_W-1:0]  r1;
    logic [KEY_W-1:0]  r2;
    int                lat;
  } exp_t;

  exp_t sb[$];
  int   n_pass  = 0;
  int   n_total = 0;

  // 2^e mod n via wide built-in modulo.
  function automatic logic [KEY_W-1:0] pow2_mod(input int e, input logic [KEY_W-1:0] n);
    logic [BW-1:0] x;
    logic [BW-1:0] nn;
    x    = '0;
    x[e] = 1'b1;
    nn   = BW'(n);
    return KEY_W'(x % nn);
  endfunction

  // -n^-1 mod 2^32 by Newton iteration (multiplier-based).
  function automatic logic [WORD_W-1:0] neg_inv(input logic [WORD_W-1:0] n);
    logic [WORD_W-1:0] x;
    x = n;
    for (int j = 0; j < 5; j++) x = x * (WORD_W'(2) - n * x);
    return WORD_W'(0) - x;
  endfunction

  function automatic vec_t mk(input logic [KEY_W-1:0] n, input logic e,
                              input logic [WORD_W-1:0] m,
                              input logic [KEY_W-1:0] a, input logic [KEY_W-1:0] b);
    vec_t v;
    v.n = n; v.err = e; v.mp = m; v.r1 = a; v.r2 = b;
    return v;
  endfunction

  function automatic vec_t mk_model(input logic [KEY_W-1:0] n);
    return mk(n, 1'b0, neg_inv(n[WORD_W-1:0]), pow2_mod(KEY_W, n), pow2_mod(2 * KEY_W, n));
  endfunction

  function automatic exp_t to_exp(input vec_t v);
    exp_t e;
    e.err = v.err; e.mp = v.mp; e.r1 = v.r1; e.r2 = v.r2;
    e.lat = v.err ? 1 : LAT_V;
    return e;
  endfunction

  task automatic check(input string name, input logic [KEY_W-1:0] act, input logic [KEY_W-1:0] want);
    n_total++;
    if (act === want) n_pass++;
    else $display("FAIL %s: got %h want %h", name, act, want);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, " busy"},     KEY_W'(busy),     '0);
    check({tag, " end_flag"}, KEY_W'(end_flag), '0);
    check({tag, " err"},      KEY_W'(err),      '0);
    check({tag, " mp"},       KEY_W'(mp),       '0);
    check({tag, " r1"},       r1,               '0);
    check({tag, " r2"},       r2,               '0);
  endtask

  // Called #1 after a rising edge; the next edge is the accepting edge T.
  task automatic drive_start(input logic [KEY_W-1:0] n, input bit push, input exp_t e);
    start   = 1'b1;
    modulos = n;
    if (push) sb.push_back(e);
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  // Waits for end_flag (bounded), optionally injecting a start at T+inj_k, then scores.
  task automatic await_result(input string tag, input int inj_k, input logic [KEY_W-1:0] inj_n);
    int   lat;
    logic busy1;
    exp_t e;
    lat   = 0;
    busy1 = 1'b0;
    for (int k = 1; k <= 700; k++) begin
      @(posedge clk);
      #1;
      if (k == 1) busy1 = busy;
      if (k == inj_k) begin
        start   = 1'b1;
        modulos = inj_n;
      end else begin
        start = 1'b0;
      end
      if (end_flag) begin
        lat = k;
        break;
      end
    end
    start = 1'b0;
    if (sb.size() == 0) begin
      $display("FAIL %s: scoreboard empty", tag);
      n_total++;
    end else begin
      e = sb.pop_front();
      check({tag, " latency"}, KEY_W'(lat), KEY_W'(e.lat));
      check({tag, " busy@T+1"}, KEY_W'(busy1), KEY_W'(!e.err));
      check({tag, " err"}, KEY_W'(err), KEY_W'(e.err));
      check({tag, " mp"}, KEY_W'(mp), KEY_W'(e.mp));
      check({tag, " r1"}, r1, e.r1);
      check({tag, " r2"}, r2, e.r2);
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    vec_t vecs[6];
    vec_t v3;
    vec_t v5;
    vec_t vbig;
    logic [KEY_W-1:0] big_n;
    logic [KEY_W-1:0] ones;

    big_n = 256'h2523648240000001ba344d80000000086121000000000013a700000000000013;
    ones  = '1;

    vbig    = mk(big_n, 1'b0, 32'hd79435e5, pow2_mod(KEY_W, big_n), pow2_mod(2 * KEY_W, big_n));
    v3      = mk(KEY_W'(3), 1'b0, 32'h55555555, KEY_W'(1), KEY_W'(1));
    v5      = mk(KEY_W'(5), 1'b0, 32'h33333333, KEY_W'(1), KEY_W'(1));
    vecs[0] = vbig;
    vecs[1] = v3;
    vecs[2] = mk(ones, 1'b0, 32'h00000001, KEY_W'(1), KEY_W'(1));
    vecs[3] = mk(KEY_W'(16), 1'b1, '0, '0, '0);
    vecs[4] = mk(KEY_W'(1), 1'b1, '0, '0, '0);
    vecs[5] = mk_model({8{32'h9e3779b9}});

    rstn    = 1'b0;
    start   = 1'b0;
    modulos = '0;
    repeat (3) @(posedge clk);
    #1;
    check_all_zero("reset");
    rstn = 1'b1;
    @(posedge clk);
    #1;

    for (int i = 0; i < 6; i++) begin
      drive_start(vecs[i].n, 1'b1, to_exp(vecs[i]));
      await_result($sformatf("vec%0d", i), 0, '0);
    end

    // A start while busy is dropped; results are for the first modulus.
    drive_start(v3.n, 1'b1, to_exp(v3));
    await_result("overlap", 100, v5.n);

    // Restart from DONE with a new modulus.
    drive_start(v5.n, 1'b1, to_exp(v5));
    await_result("restart", 0, '0);

    // Asynchronous reset in the middle of a run.
    drive_start(big_n, 1'b0, to_exp(vbig));
    repeat (199) @(posedge clk);
    #1;
    rstn = 1'b0;
    #1;
    check_all_zero("abort");
    @(posedge clk);
    #1;
    rstn = 1'b1;
    @(posedge clk);
    #1;
    drive_start(big_n, 1'b1, to_exp(vbig));
    await_result("after_abort", 0, '0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
